// File: rtl/hg_pkg.sv
// hg_pkg: shared types and constants for the homography pixel fetcher.
//   - hgState_e : fetcher FSM states
//   - rgb565_t  : RGB565 pixel layout {red, green, blue}
//   - HG_FRAC_BITS / HG_ACC_W : default fixed-point format
//   - PIX_BLACK / PIX_RED : out-of-range and error-marker pixels
//   - packRgb() : assembles an RGB565 pixel from its channels
package hg_pkg;

  localparam int HG_FRAC_BITS = 10;
  localparam int HG_ACC_W     = 24;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_PUSH    = 3'd5,
    ST_ADVANCE = 3'd6
  } hgState_e;

  typedef struct packed {
    logic [4:0] red;
    logic [5:0] green;
    logic [4:0] blue;
  } rgb565_t;

  localparam rgb565_t PIX_BLACK = rgb565_t'(16'h0000);
  localparam rgb565_t PIX_RED   = rgb565_t'(16'hF800);

  function automatic rgb565_t packRgb(input logic [4:0] r, input logic [5:0] g,
                                      input logic [4:0] b);
    rgb565_t p;
    p.red   = r;
    p.green = g;
    p.blue  = b;
    return p;
  endfunction

endpackage

// File: rtl/hg_affine_stepper.sv
// hg_affine_stepper: incremental evaluation of the affine source mapping
//   srcX = A*x + B*y + C, srcY = D*x + E*y + F
// using additions only. The row accumulators track the start of the current
// output row; the current accumulators track the current pixel. All adds wrap
// modulo 2^ACC_W, so a wrapped value simply lands out of range.
// Ports:
//   iCLK, iRST            clock, asynchronous active-low reset
//   load                  capture A,B,D,E and start at (C,F)
//   stepX                 advance one pixel along the row
//   stepRow               move to the first pixel of the next row
//   coefA..coefF          signed Q(ACC_W-FRAC_BITS).FRAC_BITS coefficients
//   srcX, srcY            low 10 bits of the integer source coordinates
//   inRangeX, inRangeY    integer coordinate lies inside the source frame
module hg_affine_stepper import hg_pkg::*; #(
  parameter int ACC_W        = HG_ACC_W,
  parameter int FRAC_BITS    = HG_FRAC_BITS,
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             load,
  input  logic             stepX,
  input  logic             stepRow,
  input  logic [ACC_W-1:0] coefA,
  input  logic [ACC_W-1:0] coefB,
  input  logic [ACC_W-1:0] coefC,
  input  logic [ACC_W-1:0] coefD,
  input  logic [ACC_W-1:0] coefE,
  input  logic [ACC_W-1:0] coefF,
  output logic [9:0]       srcX,
  output logic [9:0]       srcY,
  output logic             inRangeX,
  output logic             inRangeY
);

  logic signed [ACC_W-1:0] coefA_r, coefB_r, coefD_r, coefE_r;
  logic signed [ACC_W-1:0] rowX_r, rowY_r, curX_r, curY_r;
  logic signed [ACC_W-1:0] nextRowX_s, nextRowY_s;
  logic signed [ACC_W-1:0] intX_s, intY_s;

  assign nextRowX_s = rowX_r + coefB_r;
  assign nextRowY_s = rowY_r + coefE_r;

  // Arithmetic shift floors toward minus infinity, as required for negatives.
  assign intX_s = curX_r >>> FRAC_BITS;
  assign intY_s = curY_r >>> FRAC_BITS;

  assign inRangeX = !intX_s[ACC_W-1] && (intX_s < ACC_W'(FRAME_WIDTH));
  assign inRangeY = !intY_s[ACC_W-1] && (intY_s < ACC_W'(FRAME_HEIGHT));
  assign srcX     = intX_s[9:0];
  assign srcY     = intY_s[9:0];

  // Coefficient capture and accumulator stepping.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      coefA_r <= '0;
      coefB_r <= '0;
      coefD_r <= '0;
      coefE_r <= '0;
      rowX_r  <= '0;
      rowY_r  <= '0;
      curX_r  <= '0;
      curY_r  <= '0;
    end else if (load) begin
      coefA_r <= coefA;
      coefB_r <= coefB;
      coefD_r <= coefD;
      coefE_r <= coefE;
      rowX_r  <= coefC;
      rowY_r  <= coefF;
      curX_r  <= coefC;
      curY_r  <= coefF;
    end else if (stepRow) begin
      // The new row start is also the first pixel of that row.
      rowX_r <= nextRowX_s;
      rowY_r <= nextRowY_s;
      curX_r <= nextRowX_s;
      curY_r <= nextRowY_s;
    end else if (stepX) begin
      curX_r <= curX_r + coefA_r;
      curY_r <= curY_r + coefD_r;
    end else begin
      curX_r <= curX_r;
      curY_r <= curY_r;
    end
  end

endmodule

// File: rtl/hg_pixel_fetcher.sv
// hg_pixel_fetcher: walks the output raster, maps every output pixel through
// a fixed-point affine homography and reads the source pixel from the SRAM
// frame-buffer controller, then pushes it downstream as RGB565.
// Out-of-range source coordinates produce a black pixel without any request.
// Optional macro HG_FETCH_TIMEOUT_EN: bounds the wait for iReady to
// TIMEOUT_CYC cycles; on expiry a red pixel is emitted and oTimeout sticks.
// Ports:
//   iCLK, iRST                  clock, asynchronous active-low reset
//   iStart                      starts a frame when idle
//   iA..iF                      affine coefficients, sampled at iStart
//   oHGRequest/oHGX/oHGY/oHGCLK read request toward the controller
//   iReady, iHGRed/Green/Blue   read completion and returned colour
//   oPixValid/oPixData/iPixReady downstream pixel handshake
//   oBusy, oFrameDone           frame status
//   oTimeout                    sticky read timeout (macro build only)
module hg_pixel_fetcher import hg_pkg::*; #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int FRAC_BITS    = HG_FRAC_BITS,
  parameter int ACC_W        = HG_ACC_W
`ifdef HG_FETCH_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 64
`endif
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iStart,
  input  logic [ACC_W-1:0] iA,
  input  logic [ACC_W-1:0] iB,
  input  logic [ACC_W-1:0] iC,
  input  logic [ACC_W-1:0] iD,
  input  logic [ACC_W-1:0] iE,
  input  logic [ACC_W-1:0] iF,
  output logic             oHGRequest,
  output logic [9:0]       oHGX,
  output logic [9:0]       oHGY,
  output logic             oHGCLK,
  input  logic             iReady,
  input  logic [4:0]       iHGRed,
  input  logic [5:0]       iHGGreen,
  input  logic [4:0]       iHGBlue,
  output logic             oPixValid,
  output logic [15:0]      oPixData,
  input  logic             iPixReady,
  output logic             oBusy,
  output logic             oFrameDone
`ifdef HG_FETCH_TIMEOUT_EN
  , output logic           oTimeout
`endif
);

  localparam int XW = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
  localparam int YW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;

  hgState_e        state_r;
  logic [XW-1:0]   xCnt_r;
  logic [YW-1:0]   yCnt_r;
  logic            lastCol_s, lastRow_s;
  logic            load_s, stepX_s, stepRow_s;
  logic [9:0]      srcX_s, srcY_s;
  logic            inRangeX_s, inRangeY_s;

`ifdef HG_FETCH_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmoCnt_r;
  logic             tmoHit_s;
  assign tmoHit_s = (tmoCnt_r >= TMO_W'(TIMEOUT_CYC - 1));
`endif

  assign lastCol_s = (xCnt_r == XW'(FRAME_WIDTH - 1));
  assign lastRow_s = (yCnt_r == YW'(FRAME_HEIGHT - 1));
  assign load_s    = (state_r == ST_IDLE) && iStart;
  assign stepX_s   = (state_r == ST_ADVANCE) && !lastCol_s;
  assign stepRow_s = (state_r == ST_ADVANCE) && lastCol_s && !lastRow_s;

  hg_affine_stepper #(
    .ACC_W        (ACC_W),
    .FRAC_BITS    (FRAC_BITS),
    .FRAME_WIDTH  (FRAME_WIDTH),
    .FRAME_HEIGHT (FRAME_HEIGHT)
  ) uStepper (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .load     (load_s),
    .stepX    (stepX_s),
    .stepRow  (stepRow_s),
    .coefA    (iA),
    .coefB    (iB),
    .coefC    (iC),
    .coefD    (iD),
    .coefE    (iE),
    .coefF    (iF),
    .srcX     (srcX_s),
    .srcY     (srcY_s),
    .inRangeX (inRangeX_s),
    .inRangeY (inRangeY_s)
  );

  // Fetch FSM with raster counters and registered interface outputs.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_r    <= ST_IDLE;
      xCnt_r     <= '0;
      yCnt_r     <= '0;
      oHGRequest <= 1'b0;
      oHGX       <= 10'd0;
      oHGY       <= 10'd0;
      oHGCLK     <= 1'b0;
      oPixValid  <= 1'b0;
      oPixData   <= 16'h0000;
      oBusy      <= 1'b0;
      oFrameDone <= 1'b0;
`ifdef HG_FETCH_TIMEOUT_EN
      tmoCnt_r   <= '0;
      oTimeout   <= 1'b0;
`endif
    end else begin
      oFrameDone <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (iStart) begin
            xCnt_r  <= '0;
            yCnt_r  <= '0;
            oBusy   <= 1'b1;
            state_r <= ST_SETUP;
`ifdef HG_FETCH_TIMEOUT_EN
            oTimeout <= 1'b0;
`endif
          end
        end
        ST_SETUP: begin
          if (inRangeX_s && inRangeY_s) begin
            // Address and request rise one cycle before the strobe edge.
            oHGX       <= srcX_s;
            oHGY       <= srcY_s;
            oHGRequest <= 1'b1;
            state_r    <= ST_STROBE;
`ifdef HG_FETCH_TIMEOUT_EN
            tmoCnt_r   <= '0;
`endif
          end else begin
            oPixData  <= PIX_BLACK;
            oPixValid <= 1'b1;
            state_r   <= ST_PUSH;
          end
        end
        ST_STROBE: begin
          oHGCLK  <= 1'b1;
          state_r <= ST_WAIT;
`ifdef HG_FETCH_TIMEOUT_EN
          tmoCnt_r <= tmoCnt_r + TMO_W'(1);
`endif
        end
        ST_WAIT: begin
          if (iReady) begin
            oHGRequest <= 1'b0;
            oHGCLK     <= 1'b0;
            state_r    <= ST_CAPTURE;
          end
`ifdef HG_FETCH_TIMEOUT_EN
          else if (tmoHit_s) begin
            oHGRequest <= 1'b0;
            oHGCLK     <= 1'b0;
            oPixData   <= PIX_RED;
            oPixValid  <= 1'b1;
            oTimeout   <= 1'b1;
            state_r    <= ST_PUSH;
          end else begin
            tmoCnt_r <= tmoCnt_r + TMO_W'(1);
          end
`else
          else begin
            state_r <= ST_WAIT;
          end
`endif
        end
        ST_CAPTURE: begin
          // Returned colour is valid the cycle after iReady, i.e. now.
          oPixData  <= packRgb(iHGRed, iHGGreen, iHGBlue);
          oPixValid <= 1'b1;
          state_r   <= ST_PUSH;
        end
        ST_PUSH: begin
          if (iPixReady) begin
            oPixValid <= 1'b0;
            state_r   <= ST_ADVANCE;
            // Pulsed while still in ADVANCE so a coincident iStart is ignored.
            if (lastCol_s && lastRow_s) begin
              oFrameDone <= 1'b1;
            end
          end
        end
        ST_ADVANCE: begin
          if (lastCol_s && lastRow_s) begin
            oBusy   <= 1'b0;
            state_r <= ST_IDLE;
          end else if (lastCol_s) begin
            xCnt_r  <= '0;
            yCnt_r  <= yCnt_r + YW'(1);
            state_r <= ST_SETUP;
          end else begin
            xCnt_r  <= xCnt_r + XW'(1);
            state_r <= ST_SETUP;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hg_pixel_fetcher.sv
// tb_hg_pixel_fetcher: randomized self-checking bench for hg_pixel_fetcher on
// a 4x2 frame. Expected pixels and requests come from evaluating the affine
// mapping directly per pixel (wrapping modulo 2^ACC_W).
module tb_hg_pixel_fetcher;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int FRAC = 10;
  localparam int ACCW = 24;

  logic             iCLK = 1'b0;
  logic             iRST = 1'b0;
  logic             iStart = 1'b0;
  logic [ACCW-1:0]  iA = '0, iB = '0, iC = '0, iD = '0, iE = '0, iF = '0;
  logic             oHGRequest, oHGCLK;
  logic [9:0]       oHGX, oHGY;
  logic             iReady = 1'b0;
  logic [4:0]       iHGRed = 5'd0;
  logic [5:0]       iHGGreen = 6'd0;
  logic [4:0]       iHGBlue = 5'd0;
  logic             oPixValid;
  logic [15:0]      oPixData;
  logic             iPixReady = 1'b0;
  logic             oBusy, oFrameDone;
`ifdef HG_FETCH_TIMEOUT_EN
  logic             oTimeout;
`endif

  always #4 iCLK = ~iCLK;

  hg_pixel_fetcher #(
    .FRAME_WIDTH  (W),
    .FRAME_HEIGHT (H),
    .FRAC_BITS    (FRAC),
    .ACC_W        (ACCW)
  ) dut (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .iStart     (iStart),
    .iA         (iA),
    .iB         (iB),
    .iC         (iC),
    .iD         (iD),
    .iE         (iE),
    .iF         (iF),
    .oHGRequest (oHGRequest),
    .oHGX       (oHGX),
    .oHGY       (oHGY),
    .oHGCLK     (oHGCLK),
    .iReady     (iReady),
    .iHGRed     (iHGRed),
    .iHGGreen   (iHGGreen),
    .iHGBlue    (iHGBlue),
    .oPixValid  (oPixValid),
    .oPixData   (oPixData),
    .iPixReady  (iPixReady),
    .oBusy      (oBusy),
    .oFrameDone (oFrameDone)
`ifdef HG_FETCH_TIMEOUT_EN
    , .oTimeout (oTimeout)
`endif
  );

  int nChecks = 0;
  int nErrors = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outVec();
    return {23'd0, oHGRequest, oHGX, oHGY, oHGCLK, oPixValid, oPixData, oBusy, oFrameDone};
  endfunction

  // ---------------- reference model ----------------
  int          expReq[$];
  logic [15:0] expPix[$];

  function automatic longint wrapAcc(input longint v);
    logic signed [ACCW-1:0] t;
    t = v[ACCW-1:0];
    return t;
  endfunction

  task automatic buildExpect(input longint a, b, c, d, e, f, input bit tmo);
    expReq.delete();
    expPix.delete();
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        longint sx, sy;
        sx = wrapAcc(a * x + b * y + c) >>> FRAC;
        sy = wrapAcc(d * x + e * y + f) >>> FRAC;
        if (sx >= 0 && sx < W && sy >= 0 && sy < H) begin
          expReq.push_back(int'(sy) * 1024 + int'(sx));
          expPix.push_back(tmo ? 16'hF800 : 16'(16'h1234 + sy * W + sx));
        end else begin
          expPix.push_back(16'h0000);
        end
      end
    end
  endtask

  // ---------------- read responder ----------------
  int          reqQ[$];
  bit          respNever = 1'b0;
  bit          respRand = 1'b0;
  int          respDelay = 2;
  bit          pending = 1'b0;
  int          pendCnt = 0;
  logic        prevHgClk = 1'b0;
  logic [9:0]  reqX = 10'd0, reqY = 10'd0;
  logic [15:0] respData;

  always @(negedge iCLK) begin
    if (!iRST) begin
      pending   = 1'b0;
      iReady    = 1'b0;
      prevHgClk = 1'b0;
    end else begin
      iReady = 1'b0;
      if (oHGCLK && !prevHgClk) begin
        checkVal("strobe_req", 64'(oHGRequest), 64'd1);
        reqQ.push_back(int'(oHGY) * 1024 + int'(oHGX));
        reqX    = oHGX;
        reqY    = oHGY;
        pending = !respNever;
        pendCnt = respRand ? int'($urandom_range(0, 4)) : respDelay;
      end else if (pending) begin
        checkVal("req_hold", {44'd0, oHGRequest, oHGCLK, oHGY, oHGX}, {44'd0, 2'b11, reqY, reqX});
      end
      if (pending) begin
        if (pendCnt == 0) begin
          respData = 16'h1234 + 16'(reqY * W + reqX);
          iHGRed   = respData[15:11];
          iHGGreen = respData[10:5];
          iHGBlue  = respData[4:0];
          iReady   = 1'b1;
          pending  = 1'b0;
        end else begin
          pendCnt--;
        end
      end
      prevHgClk = oHGCLK;
    end
  end

  // ---------------- downstream sink ----------------
  logic [15:0] pixQ[$];
  bit          readyRand = 1'b0;
  int          stallLeft = 0;
  logic        lastValid = 1'b0, lastReady = 1'b0;
  logic [15:0] lastData = 16'h0000;

  always @(negedge iCLK) begin
    if (!iRST) begin
      lastValid = 1'b0;
      lastReady = 1'b0;
      iPixReady = 1'b0;
    end else begin
      if (lastValid && lastReady) begin
        pixQ.push_back(lastData);
      end else if (lastValid) begin
        checkVal("push_hold", {46'd0, oHGCLK, oPixValid, oPixData}, {46'd0, 1'b0, 1'b1, lastData});
      end
      lastValid = oPixValid;
      lastData  = oPixData;
      if (stallLeft > 0 && oPixValid) begin
        iPixReady = 1'b0;
        stallLeft--;
      end else if (readyRand) begin
        iPixReady = ($urandom_range(0, 3) != 0);
      end else begin
        iPixReady = 1'b1;
      end
      lastReady = iPixReady;
    end
  end

  // ---------------- frame runner ----------------
  task automatic runFrame(input string name, input longint a, b, c, d, e, f, input bit tmo);
    bit done;
    int cyc;
    int extra;
    buildExpect(a, b, c, d, e, f, tmo);
    pixQ.delete();
    reqQ.delete();
    @(negedge iCLK);
    iA = a[ACCW-1:0];
    iB = b[ACCW-1:0];
    iC = c[ACCW-1:0];
    iD = d[ACCW-1:0];
    iE = e[ACCW-1:0];
    iF = f[ACCW-1:0];
    iStart = 1'b1;
    @(negedge iCLK);
    iStart = 1'b0;
    // Coefficients must have been latched at iStart.
    iA = ACCW'($urandom); iB = ACCW'($urandom); iC = ACCW'($urandom);
    iD = ACCW'($urandom); iE = ACCW'($urandom); iF = ACCW'($urandom);
    checkVal({name, "_busy"}, 64'(oBusy), 64'd1);
`ifdef HG_FETCH_TIMEOUT_EN
    checkVal({name, "_tmo_clr"}, 64'(oTimeout), 64'd0);
`endif
    done = 1'b0;
    cyc  = 0;
    while (!done && cyc < 4000) begin
      @(negedge iCLK);
      cyc++;
      if (oFrameDone) done = 1'b1;
    end
    checkVal({name, "_done"}, 64'(done), 64'd1);
    // A start coinciding with oFrameDone must be ignored.
    iStart = 1'b1;
    @(negedge iCLK);
    iStart = 1'b0;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      if (oFrameDone || oBusy || oHGRequest) extra++;
      @(negedge iCLK);
    end
    checkVal({name, "_idle_after"}, 64'(extra), 64'd0);
    checkVal({name, "_npix"}, 64'(pixQ.size()), 64'(expPix.size()));
    for (int i = 0; i < pixQ.size() && i < expPix.size(); i++)
      checkVal($sformatf("%s_pix%0d", name, i), 64'(pixQ[i]), 64'(expPix[i]));
    checkVal({name, "_nreq"}, 64'(reqQ.size()), 64'(expReq.size()));
    for (int i = 0; i < reqQ.size() && i < expReq.size(); i++)
      checkVal($sformatf("%s_req%0d", name, i), 64'(reqQ[i]), 64'(expReq[i]));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    longint ra, rb, rc, rd, re, rf;
    bit     seen;
    repeat (3) @(negedge iCLK);
    checkVal("rst_outputs", outVec(), 64'd0);
    iRST = 1'b1;
    @(negedge iCLK);
    checkVal("idle_outputs", outVec(), 64'd0);

    respDelay = 2;
    runFrame("ident", 1024, 0, 0, 0, 1024, 0, 1'b0);
    runFrame("negc", 1024, 0, -2048, 0, 1024, 0, 1'b0);
    stallLeft = 10;
    runFrame("stall", 1024, 0, 0, 0, 1024, 0, 1'b0);
    checkVal("stall_used", 64'(stallLeft), 64'd0);
    runFrame("scale", 512, 0, 0, 0, 512, 0, 1'b0);
    runFrame("wrap", longint'(1) << 23, 0, 2048, 0, 1024, 0, 1'b0);

    // Reset while waiting for a read aborts the frame.
    respNever = 1'b1;
    pixQ.delete();
    @(negedge iCLK);
    iA = 24'd1024; iB = 24'd0; iC = 24'd0; iD = 24'd0; iE = 24'd1024; iF = 24'd0;
    iStart = 1'b1;
    @(negedge iCLK);
    iStart = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge iCLK);
      if (oHGCLK) seen = 1'b1;
    end
    checkVal("rst_reach_wait", 64'(seen), 64'd1);
    iRST = 1'b0;
    #1;
    checkVal("rst_async", outVec(), 64'd0);
    @(negedge iCLK);
    iRST = 1'b1;
    respNever = 1'b0;
    repeat (3) @(negedge iCLK);
    checkVal("rst_nopix", 64'(pixQ.size()), 64'd0);
    checkVal("rst_idle", outVec(), 64'd0);
    runFrame("post_rst", 1024, 0, 0, 0, 1024, 0, 1'b0);

    // Randomized coefficients, response delays and downstream back-pressure.
    respRand  = 1'b1;
    readyRand = 1'b1;
    for (int k = 0; k < 6; k++) begin
      ra = longint'($urandom_range(0, 2048)) - 512;
      rb = longint'($urandom_range(0, 1024)) - 512;
      rc = longint'($urandom_range(0, 6144)) - 2048;
      rd = longint'($urandom_range(0, 1024)) - 512;
      re = longint'($urandom_range(0, 2048)) - 512;
      rf = longint'($urandom_range(0, 3072)) - 1024;
      runFrame($sformatf("rand%0d", k), ra, rb, rc, rd, re, rf, 1'b0);
    end
    respRand  = 1'b0;
    readyRand = 1'b0;

`ifdef HG_FETCH_TIMEOUT_EN
    respNever = 1'b1;
    runFrame("tmo", 1024, 0, -2048, 0, 1024, 0, 1'b1);
    checkVal("tmo_flag", 64'(oTimeout), 64'd1);
    respNever = 1'b0;
    runFrame("tmo_after", 1024, 0, 0, 0, 1024, 0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
